// File: rtl/duty_meas_if.sv
// Duty measurement bus: signal under test in, latched results out.
// Ports: ft (in), tH/T/duty/valid/no_sig/busy (out from slave).
interface duty_meas_if #(
    parameter int CNT_W = 20
);
    logic             ft;
    logic [CNT_W-1:0] tH;
    logic [CNT_W-1:0] T;
    logic [9:0]       duty;
    logic             valid;
    logic             no_sig;
    logic             busy;

    modport master (
        output ft,
        input  tH, T, duty, valid, no_sig, busy
    );

    modport slave (
        input  ft,
        output tH, T, duty, valid, no_sig, busy
    );
endinterface

// File: rtl/duty_meas.sv
// Period / high-time / duty (permille) meter for an asynchronous input.
// Ports: c0 clock, rst sync active-high reset, m = duty_meas_if slave.
module duty_meas #(
    parameter int CNT_W     = 20,
    parameter int PCT_SCALE = 1000
) (
    input  logic        c0,
    input  logic        rst,
    duty_meas_if.slave  m
);
    localparam int DW   = CNT_W + 10;
    localparam int IW   = $clog2(DW + 1);
    localparam logic [CNT_W-1:0] CMAX = '1;
    localparam logic [IW-1:0]    LAST = IW'(DW - 1);

    typedef enum logic [1:0] {IDLE, HIGH, LOW, DIV} state_t;

    state_t state, state_nx;

    logic             s1, s2, s3;
    logic [2:0]       vld;
    logic             armed, arm_ok;
    logic             rise, fall, edge_p;
    logic             tmo, last;

    logic [CNT_W-1:0] per_cnt, hi_cnt, to_cnt;
    logic [CNT_W-1:0] dvs, rem, rem_nx;
    logic [CNT_W:0]   rem_sh;
    logic [DW-1:0]    dvd;
    logic [9:0]       q, q_nx;
    logic [IW-1:0]    it_cnt;
    logic             ge;

    logic [CNT_W-1:0] th_q, t_q;
    logic [9:0]       duty_q;
    logic             valid_q, nosig_q;

    // vld tracks which sync stages hold real samples since reset; a
    // rise is only accepted once the delayed stage has really been low.
    assign arm_ok = armed | (vld[2] & ~s3);
    assign rise   = s2 & ~s3 & arm_ok;
    assign fall   = ~s2 & s3;
    assign edge_p = rise | fall;
    assign last   = (it_cnt == LAST);

    // per_cnt guard keeps the period counter from wrapping when both
    // phases are long but each individually stays under the timeout.
    assign tmo = (state != DIV) &
                 (((to_cnt == CMAX) & ~edge_p) | (per_cnt == CMAX));

    assign rem_sh = {rem, dvd[DW-1]};
    assign ge     = (rem_sh >= {1'b0, dvs});
    assign rem_nx = ge ? CNT_W'(rem_sh - {1'b0, dvs}) : rem_sh[CNT_W-1:0];
    // Quotient never exceeds PCT_SCALE-1, so only 10 bits are kept.
    assign q_nx   = {q[8:0], ge};

    always_ff @(posedge c0) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            s3    <= 1'b0;
            vld   <= '0;
            armed <= 1'b0;
        end else begin
            s1    <= m.ft;
            s2    <= s1;
            s3    <= s2;
            vld   <= {vld[1:0], 1'b1};
            armed <= arm_ok;
        end
    end

    always_ff @(posedge c0) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (!tmo && rise) state_nx = HIGH;
            HIGH: if (tmo) state_nx = IDLE;
                  else if (fall) state_nx = LOW;
            LOW:  if (tmo) state_nx = IDLE;
                  else if (rise) state_nx = DIV;
            DIV:  if (last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge c0) begin
        if (rst || state == DIV || tmo) to_cnt <= '0;
        else if (edge_p)                to_cnt <= '0;
        else                            to_cnt <= to_cnt + 1'b1;
    end

    always_ff @(posedge c0) begin
        if (rst) begin
            per_cnt <= '0;
            hi_cnt  <= '0;
            dvs     <= '0;
            dvd     <= '0;
            rem     <= '0;
            q       <= '0;
            it_cnt  <= '0;
            th_q    <= '0;
            t_q     <= '0;
            duty_q  <= '0;
            valid_q <= 1'b0;
            nosig_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (tmo) begin
                per_cnt <= '0;
                hi_cnt  <= '0;
                th_q    <= '0;
                t_q     <= '0;
                duty_q  <= '0;
                nosig_q <= 1'b1;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (rise) begin
                            per_cnt <= CNT_W'(1);
                            hi_cnt  <= CNT_W'(1);
                        end
                    end
                    HIGH: begin
                        per_cnt <= per_cnt + 1'b1;
                        if (!fall) hi_cnt <= hi_cnt + 1'b1;
                    end
                    LOW: begin
                        if (rise) begin
                            dvs    <= per_cnt;
                            dvd    <= DW'(hi_cnt) * DW'(PCT_SCALE);
                            rem    <= '0;
                            q      <= '0;
                            it_cnt <= '0;
                        end else begin
                            per_cnt <= per_cnt + 1'b1;
                        end
                    end
                    DIV: begin
                        rem    <= rem_nx;
                        q      <= q_nx;
                        dvd    <= {dvd[DW-2:0], 1'b0};
                        it_cnt <= it_cnt + 1'b1;
                        if (last) begin
                            th_q    <= hi_cnt;
                            t_q     <= dvs;
                            duty_q  <= q_nx;
                            valid_q <= 1'b1;
                            nosig_q <= 1'b0;
                            per_cnt <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign m.tH     = th_q;
    assign m.T      = t_q;
    assign m.duty   = duty_q;
    assign m.valid  = valid_q;
    assign m.no_sig = nosig_q;
    assign m.busy   = (state != IDLE);
endmodule

// File: tb/tb_duty_meas.sv
// Scoreboard bench for duty_meas: CNT_W=20 and CNT_W=8 instances.
// Stimulus pushes expected results; monitors pop on valid.
module tb_duty_meas;
    logic c0 = 1'b0;
    logic rst;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always #5 c0 = ~c0;
    always @(posedge c0) cyc <= cyc + 1;

    duty_meas_if #(.CNT_W(20)) bus ();
    duty_meas_if #(.CNT_W(8))  bus8 ();

    duty_meas #(.CNT_W(20), .PCT_SCALE(1000)) dut (
        .c0(c0), .rst(rst), .m(bus)
    );
    duty_meas #(.CNT_W(8), .PCT_SCALE(1000)) dut8 (
        .c0(c0), .rst(rst), .m(bus8)
    );

    typedef struct {
        int t;
        int th;
        int duty;
        int cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q8[$];
    exp_t e0, e8;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge c0);
    endtask

    task automatic set_ft(input bit w8, input logic v);
        if (w8) bus8.ft = v;
        else    bus.ft  = v;
    endtask

    // Every second rise closes a measurement; valid is due 2 sync cycles
    // plus CNT_W+11 after the cycle the rise was driven.
    task automatic wave(input bit w8, input int per, input int hi,
                        input int nrise, input int exp_duty);
        exp_t e;
        for (int i = 0; i < nrise; i++) begin
            set_ft(w8, 1'b1);
            if (i % 2 == 1) begin
                e.t    = per;
                e.th   = hi;
                e.duty = exp_duty;
                e.cyc  = cyc + (w8 ? 21 : 33);
                if (w8) q8.push_back(e);
                else    q0.push_back(e);
            end
            tick(hi);
            set_ft(w8, 1'b0);
            tick(per - hi);
        end
    endtask

    always @(negedge c0) begin
        if (bus.valid) begin
            if (q0.size() == 0) begin
                chk("unexpected_valid0", 1, 0);
            end else begin
                e0 = q0.pop_front();
                chk("T0", int'(bus.T), e0.t);
                chk("tH0", int'(bus.tH), e0.th);
                chk("duty0", int'(bus.duty), e0.duty);
                chk("no_sig0", int'(bus.no_sig), 0);
                chk("lat0", cyc, e0.cyc);
            end
        end
    end

    always @(negedge c0) begin
        if (bus8.valid) begin
            if (q8.size() == 0) begin
                chk("unexpected_valid8", 1, 0);
            end else begin
                e8 = q8.pop_front();
                chk("T8", int'(bus8.T), e8.t);
                chk("tH8", int'(bus8.tH), e8.th);
                chk("duty8", int'(bus8.duty), e8.duty);
                chk("no_sig8", int'(bus8.no_sig), 0);
                chk("lat8", cyc, e8.cyc);
            end
        end
    end

    initial begin
        rst     = 1'b1;
        bus.ft  = 1'b0;
        bus8.ft = 1'b0;
        tick(5);
        chk("rst_tH", int'(bus.tH), 0);
        chk("rst_T", int'(bus.T), 0);
        chk("rst_duty", int'(bus.duty), 0);
        chk("rst_valid", int'(bus.valid), 0);
        chk("rst_no_sig", int'(bus.no_sig), 0);
        chk("rst_busy", int'(bus.busy), 0);
        rst = 1'b0;
        tick(5);

        wave(1'b0, 200, 50, 2, 250);
        tick(60);
        wave(1'b0, 3, 1, 2, 333);
        tick(60);
        wave(1'b0, 7, 6, 2, 857);
        tick(60);
        wave(1'b0, 1000, 999, 2, 999);
        tick(60);
        wave(1'b0, 100, 70, 6, 700);
        tick(60);

        // Reset in the middle of a high phase, ft still high afterwards.
        bus.ft = 1'b1;
        tick(10);
        chk("busy_high", int'(bus.busy), 1);
        rst = 1'b1;
        tick(1);
        chk("mid_rst_tH", int'(bus.tH), 0);
        chk("mid_rst_T", int'(bus.T), 0);
        chk("mid_rst_duty", int'(bus.duty), 0);
        chk("mid_rst_valid", int'(bus.valid), 0);
        chk("mid_rst_busy", int'(bus.busy), 0);
        rst = 1'b0;
        tick(9);
        bus.ft = 1'b0;
        tick(80);
        wave(1'b0, 100, 30, 2, 300);
        tick(60);

        // Timeout on the narrow instance: hold ft high after one rise.
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(5);
        bus8.ft = 1'b1;
        tick(200);
        chk("no_sig8_early", int'(bus8.no_sig), 0);
        tick(100);
        chk("no_sig8_tmo", int'(bus8.no_sig), 1);
        tick(300);
        chk("no_sig8_hold", int'(bus8.no_sig), 1);
        chk("tmo_tH8", int'(bus8.tH), 0);
        chk("tmo_T8", int'(bus8.T), 0);
        chk("tmo_duty8", int'(bus8.duty), 0);
        bus8.ft = 1'b0;
        tick(20);
        wave(1'b1, 40, 10, 2, 250);
        tick(40);
        chk("no_sig8_clr", int'(bus8.no_sig), 0);

        for (int i = 0; i < 500 && (q0.size() != 0 || q8.size() != 0); i++)
            tick(1);
        chk("pending0", q0.size(), 0);
        chk("pending8", q8.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/duty_meas.md
DUTY_MEAS -- requirements
Module: duty_meas

Interface
REQ-001 Parameter CNT_W, default 20, width of the period and high-time counters in c0 cycles.
REQ-002 Parameter PCT_SCALE, default 1000, full-scale value of the duty result (permille).
REQ-003 c0  input  1  measurement clock (100 MHz from PLL); all logic on its rising edge; the only clock.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 ft  input  1  asynchronous signal under test.
REQ-006 tH  output  CNT_W  latched high time, c0 cycles.
REQ-007 T  output  CNT_W  latched period, c0 cycles.
REQ-008 duty  output  10  floor(tH*PCT_SCALE/T).
REQ-009 valid  output  1  one-cycle pulse: tH/T/duty updated this cycle.
REQ-010 no_sig  output  1  level: no required ft edge within timeout.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 ft passes a 2-flop synchronizer plus a third delay flop; rise pulse = sync&~dly, fall pulse = ~sync&dly; all timing is measured between these pulses.
REQ-013 FSM states: IDLE, HIGH, LOW, DIV.
REQ-014 IDLE: wait for rise pulse -> HIGH; period and high counters set to 1 in that cycle; fall pulses ignored.
REQ-015 HIGH: both counters increment each cycle; on fall pulse, high counter frozen, -> LOW.
REQ-016 LOW: period counter increments; on rise pulse, capture T = period count and tH = high count, -> DIV.
REQ-017 Result: rise pulses at cycles a and b, fall pulse at cycle f -> T = b-a, tH = f-a.
REQ-018 DIV: restoring divider, one quotient bit per cycle, dividend tH*PCT_SCALE (CNT_W+10 bits), divisor T, CNT_W+10 iterations; remainder discarded (floor).
REQ-019 Cycle after the last iteration: tH, T, duty registered together, valid = 1 for exactly one cycle, no_sig cleared, -> IDLE.
REQ-020 Latency: valid asserted CNT_W+11 cycles after the terminating rise pulse (31 cycles at default).
REQ-021 Edges during DIV ignored; next measurement starts at the first rise pulse seen in IDLE (consecutive results use every other period at most).
REQ-022 tH < T always holds, so duty is at most PCT_SCALE-1; no saturation logic required.
REQ-023 Timeout: a counter cleared on every rise or fall pulse and on entry to IDLE; on reaching 2^CNT_W-1 in IDLE, HIGH or LOW, no_sig = 1, tH/T/duty = 0, valid stays 0, -> IDLE.
REQ-024 Counters never wrap; timeout fires before any counter overflows.
REQ-025 no_sig holds until the next valid pulse or reset.
REQ-026 Outputs hold their last value between valid pulses.

Reset
REQ-027 rst, checked each c0 edge, forces IDLE and clears synchronizer, counters and divider in the same cycle.
REQ-028 Reset output values: tH = 0, T = 0, duty = 0, valid = 0, no_sig = 0, busy = 0.
REQ-029 Reset during HIGH, LOW or DIV discards the partial measurement; no valid pulse results from it.
REQ-030 ft high when rst deasserts: no rise pulse is generated until ft goes low and then high again.

Verification
REQ-031 ft period 200 cycles, high 50, CNT_W=20 -> valid pulse, T=200, tH=50, duty=250, no_sig=0.
REQ-032 ft period 3 cycles, high 1 -> T=3, tH=1, duty=333; valid exactly 31 cycles after the closing rise pulse.
REQ-033 CNT_W=8, ft held 1 after one rise -> no_sig=1 after 255 cycles without an edge, outputs 0, no valid; then a 40/10 waveform -> T=40, tH=10, duty=250, no_sig=0.
REQ-034 rst pulsed for 1 cycle mid-HIGH -> next cycle all outputs 0, busy=0; the following full period measures correctly.
REQ-035 Continuous 100/70 waveform -> valid every second period, T=100, tH=70, duty=700 each time; edges during DIV produce no corruption.
REQ-036 Period 7, high 6 -> duty=857 (floor check); period 1000, high 999 -> duty=999.
